// File: rtl/rv_constants.sv
// Shared RISC-V constants: ALU op codes plus the serial divider's state
// encoding and iteration count.
package rv_constants;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLL   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_SLT   = 5'd8;
    localparam logic [4:0] ALU_SLTU  = 5'd9;
    localparam logic [4:0] ALU_MUL   = 5'd10;
    localparam logic [4:0] ALU_MULH  = 5'd11;
    localparam logic [4:0] ALU_DIV   = 5'd12;
    localparam logic [4:0] ALU_DIVU  = 5'd13;
    localparam logic [4:0] ALU_REM   = 5'd14;
    localparam logic [4:0] ALU_REMU  = 5'd15;

    localparam int DIV_ITERATIONS = 32;
    localparam int DIV_COUNT_W    = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [4:0] fn);
        return (fn == ALU_DIV) || (fn == ALU_DIVU) || (fn == ALU_REM) || (fn == ALU_REMU);
    endfunction

    function automatic logic is_signed_div_op(input logic [4:0] fn);
        return (fn == ALU_DIV) || (fn == ALU_REM);
    endfunction

    function automatic logic is_quotient_op(input logic [4:0] fn);
        return (fn == ALU_DIV) || (fn == ALU_DIVU);
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Fixed-latency restoring divider: one shift-subtract step per cycle on operand
// magnitudes, sign correction applied when the result is latched into DONE.
module serial_divider
    import rv_constants::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  alu_function,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [DIV_COUNT_W-1:0] LAST_COUNT = DIV_COUNT_W'(DIV_ITERATIONS);

    div_state_e             state_q, state_d;
    logic [DIV_COUNT_W-1:0] count_q, count_d;
    logic [31:0]            rem_q, rem_d;
    logic [31:0]            quo_q, quo_d;
    logic [31:0]            divisor_q, divisor_d;
    logic [4:0]             op_q, op_d;
    logic                   a_neg_q, a_neg_d;
    logic                   q_neg_q, q_neg_d;
    logic [31:0]            result_q, result_d;

    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        in_signed;
    logic        in_a_neg;
    logic        in_b_neg;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        q_neg_d   = q_neg_q;
        result_d  = result_q;

        // Dividend bits enter the partial remainder from the top of the quotient
        // register; a clear bit 32 of the difference means the subtract fits.
        rem_shift = {rem_q, quo_q[31]};
        rem_diff  = rem_shift - {1'b0, divisor_q};

        in_signed = is_signed_div_op(alu_function);
        in_a_neg  = in_signed & operand_a[31];
        in_b_neg  = in_signed & operand_b[31];

        case (state_q)
            DIV_IDLE: begin
                if (start && is_div_op(alu_function)) begin
                    state_d   = DIV_RUN;
                    count_d   = '0;
                    rem_d     = '0;
                    op_d      = alu_function;
                    quo_d     = in_a_neg ? (32'd0 - operand_a) : operand_a;
                    divisor_d = in_b_neg ? (32'd0 - operand_b) : operand_b;
                    a_neg_d   = in_a_neg;
                    q_neg_d   = (in_a_neg ^ in_b_neg) && (operand_b != 32'd0);
                end
            end
            DIV_RUN: begin
                if (count_q == LAST_COUNT) begin
                    state_d = DIV_DONE;
                    // Divide-by-zero and signed overflow fall out of the plain
                    // magnitude division, so only the sign fix-up is needed here.
                    if (is_quotient_op(op_q)) begin
                        result_d = q_neg_q ? (32'd0 - quo_q) : quo_q;
                    end else begin
                        result_d = a_neg_q ? (32'd0 - rem_q) : rem_q;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                    if (!rem_diff[32]) begin
                        rem_d = rem_diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            op_q      <= '0;
            a_neg_q   <= 1'b0;
            q_neg_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            op_q      <= op_d;
            a_neg_q   <= a_neg_d;
            q_neg_q   <= q_neg_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != DIV_IDLE);
    assign done   = (state_q == DIV_DONE);
    assign result = result_q;

endmodule

// File: doc/serial_divider.md
SERIAL_DIVIDER -- requirements
Module: serial_divider

Interface
REQ-001 SHALL declare no parameters; iteration count fixed at 32.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: alu_function  input  5  ALU op code; accepted values are ALU_DIV, ALU_DIVU, ALU_REM and ALU_REMU.
REQ-006 SHALL have port: operand_a  input  32  dividend.
REQ-007 SHALL have port: operand_b  input  32  divisor.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have port: result  output  32  quotient or remainder.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 SHALL move IDLE->RUN on an edge where start=1 and alu_function is an accepted op.
REQ-013 SHALL ignore start when not in IDLE, or when alu_function is not an accepted op.
REQ-014 SHALL latch operands, op and the signs on the accepting edge; later input changes are ignored.
REQ-015 SHALL, in RUN, perform one restoring shift-subtract step per cycle on |a| and |b| (unsigned magnitudes for DIVU/REMU), for exactly 32 cycles.
REQ-016 SHALL use a 33-bit partial remainder for the subtract/compare.
REQ-017 SHALL go RUN->DONE after the 32nd step, then DONE->IDLE on the next edge.
REQ-018 SHALL hold busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-019 SHALL assert done=1 only in DONE; if start was accepted at edge E0, done is high for the cycle following edge E33.
REQ-020 SHALL apply the same fixed latency to every operation, including special cases.
REQ-021 SHALL, for DIV, negate the quotient when the signs of a and b differ and b != 0.
REQ-022 SHALL, for REM, give the remainder the sign of a.
REQ-023 SHALL, on divide by zero, return quotient 0xFFFFFFFF for DIV and DIVU, and remainder = a for REM and REMU.
REQ-024 SHALL, on signed overflow (a=0x80000000, b=0xFFFFFFFF), return 0x80000000 for DIV and 0 for REM.
REQ-025 SHALL update result when entering DONE and hold it until the next accepted start completes.
REQ-026 SHALL leave result undisturbed by ignored starts.
REQ-027 SHALL NOT accept a start arriving in the DONE cycle; it is ignored, and a new start is accepted from IDLE only.

Reset
REQ-028 SHALL, on reset=1 at an edge, force IDLE, busy=0, done=0, result=0, and clear the counter and remainder.
REQ-029 SHALL give reset priority over start and over any state transition.
REQ-030 SHALL abort an operation reset mid-RUN with no done pulse.

Structure
REQ-031 SHALL take ALU_DIV, ALU_DIVU, ALU_REM and ALU_REMU from the shared rv_constants package.
REQ-032 SHALL add the divider state enum and the constant DIV_ITERATIONS=32 to rv_constants.
REQ-033 SHALL be a single module with no sub-module; the step datapath is small enough to keep inline.

Verification
REQ-034 SHALL cover: DIVU 100/7 -> result 14; busy high for 33 cycles; done pulses exactly once, at E33.
REQ-035 SHALL cover: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD, and REM same operands -> 0xFFFFFFFF.
REQ-036 SHALL cover: DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF, and REMU 5/0 -> 5, each with the normal 33-cycle latency.
REQ-037 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM same operands -> 0.
REQ-038 SHALL cover both of these:
- start with alu_function=ALU_ADD -> busy stays 0;
- second start at cycle 5 of RUN with different operands -> ignored, first result delivered unchanged.
REQ-039 SHALL cover: reset asserted at cycle 10 of RUN -> next cycle busy=0, result=0, no done; a fresh DIVU 9/3 afterwards -> 3.
